// File: rtl/uart_tx_mmio_if.sv
// CPU-side register bus for the memory-mapped UART transmitter.
// The CPU (master) drives address/direction/write data; the peripheral answers with select/read data.
interface uart_tx_mmio_if;
  logic [15:0] address;
  logic        read_write;
  logic [7:0]  data_write;
  logic [7:0]  data_read;
  logic        select;

  modport master (
    output address,
    output read_write,
    output data_write,
    input  data_read,
    input  select
  );

  modport slave (
    input  address,
    input  read_write,
    input  data_write,
    output data_read,
    output select
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: DATA register feeds a small FIFO,
// STATUS/CTRL register exposes FIFO/line state and the transmit-empty interrupt.
module uart_tx_mmio #(
  parameter logic [15:0] BASE_ADDR    = 16'hD000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_mmio_if.slave  bus,
  output logic           tx,
  output logic           irq
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  COUNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]       STATUS_ADDR = BASE_ADDR + 16'd1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              irq_en_reg;
  logic              overflow_reg;

  logic [1:0]        state_reg;
  logic [BAUD_W-1:0] baud_reg;
  logic [2:0]        bit_idx_reg;
  logic [7:0]        shift_reg;
  logic              tx_reg;

  logic       select;
  logic       wr_strobe;
  logic       data_wr;
  logic       ctrl_wr;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       baud_done;
  logic [7:0] status;

  assign select     = (bus.address == BASE_ADDR) || (bus.address == STATUS_ADDR);
  assign wr_strobe  = select & ~bus.read_write;
  assign data_wr    = wr_strobe & (bus.address == BASE_ADDR);
  assign ctrl_wr    = wr_strobe & (bus.address == STATUS_ADDR);

  assign fifo_full  = (count_reg == COUNT_FULL);
  assign fifo_empty = (count_reg == '0);
  assign push       = data_wr & ~fifo_full;
  assign baud_done  = (baud_reg == BAUD_LAST);

  // The FSM takes the head either from IDLE or at the very last stop-bit cycle,
  // which is what makes back-to-back frames contiguous.
  assign pop = ~fifo_empty & ((state_reg == ST_IDLE) | ((state_reg == ST_STOP) & baud_done));

  assign status = {irq_en_reg, 3'b000, overflow_reg, (state_reg != ST_IDLE), fifo_empty, fifo_full};

  assign bus.select    = select;
  assign bus.data_read = (bus.address == STATUS_ADDR) ? status : 8'h00;
  assign irq           = irq_en_reg & fifo_empty;
  assign tx            = tx_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.data_write;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      irq_en_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (!push && pop) begin
        count_reg <= count_reg - 1'b1;
      end
      if (data_wr && fifo_full) begin
        overflow_reg <= 1'b1;
      end else if (ctrl_wr && bus.data_write[3]) begin
        overflow_reg <= 1'b0;
      end
      if (ctrl_wr) begin
        irq_en_reg <= bus.data_write[7];
      end
    end
  end

  // tx is updated on the same edge as the state change so the line is glitch-free.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            shift_reg <= mem[rd_ptr_reg];
            baud_reg  <= '0;
            tx_reg    <= 1'b0;
            state_reg <= ST_START;
          end
        end
        ST_START: begin
          if (baud_done) begin
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            tx_reg      <= shift_reg[0];
            state_reg   <= ST_DATA;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= ST_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
              tx_reg      <= shift_reg[1];
              shift_reg   <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_done) begin
            baud_reg <= '0;
            if (pop) begin
              shift_reg <= mem[rd_ptr_reg];
              tx_reg    <= 1'b0;
              state_reg <= ST_START;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio; the reference model schedules whole frames
// (arrival edge, start edge, byte) and derives line level, occupancy and status from that schedule.
module tb_uart_tx_mmio;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam logic [15:0] DATA_ADDR = 16'hD000;
  localparam logic [15:0] STAT_ADDR = 16'hD001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx;
  logic irq;

  uart_tx_mmio_if bus();

  uart_tx_mmio #(
    .BASE_ADDR(16'hD000),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .tx(tx),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference schedule: byte accepted at edge f_arr, popped (start bit begins) at edge f_start.
  int         f_arr[$];
  int         f_start[$];
  logic [7:0] f_byte[$];
  logic       m_irq_en = 1'b0;
  logic       m_ovf    = 1'b0;

  function automatic void model_reset();
    f_arr.delete();
    f_start.delete();
    f_byte.delete();
    m_irq_en = 1'b0;
    m_ovf    = 1'b0;
  endfunction

  function automatic int model_occ(input int t);
    int n = 0;
    for (int i = 0; i < f_arr.size(); i++)
      if (f_arr[i] <= t && f_start[i] > t) n++;
    return n;
  endfunction

  function automatic logic model_active(input int t);
    for (int i = 0; i < f_start.size(); i++)
      if (t >= f_start[i] && t < f_start[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic model_tx(input int t);
    logic [7:0] b;
    int k;
    for (int i = 0; i < f_start.size(); i++) begin
      if (t >= f_start[i] && t < f_start[i] + FRAME) begin
        k = (t - f_start[i]) / CPB;
        b = f_byte[i];
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [7:0] model_status(input int t);
    int occ = model_occ(t);
    return {m_irq_en, 3'b000, m_ovf, model_active(t), (occ == 0), (occ == DEPTH)};
  endfunction

  function automatic logic model_irq(input int t);
    return m_irq_en & (model_occ(t) == 0);
  endfunction

  // A byte is dropped if the FIFO was full just before its write edge; otherwise it
  // starts one edge later, or right after the previous frame if the line is still busy.
  function automatic void model_data(input int a, input logic [7:0] d);
    int s;
    if (model_occ(a - 1) == DEPTH) begin
      m_ovf = 1'b1;
    end else begin
      s = a + 1;
      if (f_start.size() > 0 && f_start[f_start.size()-1] + FRAME > s)
        s = f_start[f_start.size()-1] + FRAME;
      f_arr.push_back(a);
      f_start.push_back(s);
      f_byte.push_back(d);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    bus.address    = a;
    bus.read_write = 1'b0;
    bus.data_write = d;
    tick();
    bus.address    = 16'h0000;
    bus.read_write = 1'b1;
    if (a == DATA_ADDR) begin
      model_data(cyc, d);
    end else if (a == STAT_ADDR) begin
      m_irq_en = d[7];
      if (d[3]) m_ovf = 1'b0;
    end
  endtask

  task automatic read_status(output logic [7:0] v);
    bus.address    = STAT_ADDR;
    bus.read_write = 1'b1;
    #1;
    v = bus.data_read;
    bus.address = 16'h0000;
  endtask

  task automatic test_reset();
    logic [7:0] st;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    model_reset();
    read_status(st);
    checks++;
    if (st !== 8'h02) begin errors++; $display("FAIL reset_status got=%h exp=%h", st, 8'h02); end
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    bus.address = STAT_ADDR;
    #1;
    checks++;
    if (bus.select !== 1'b1) begin errors++; $display("FAIL reset_select_stat got=%b exp=1", bus.select); end
    bus.address = DATA_ADDR;
    #1;
    checks++;
    if (bus.select !== 1'b1 || bus.data_read !== 8'h00) begin
      errors++; $display("FAIL data_read_zero sel=%b rd=%h exp sel=1 rd=00", bus.select, bus.data_read);
    end
    bus.address = 16'hD002;
    #1;
    checks++;
    if (bus.select !== 1'b0 || bus.data_read !== 8'h00) begin
      errors++; $display("FAIL unselected sel=%b rd=%h exp sel=0 rd=00", bus.select, bus.data_read);
    end
    bus.address = 16'h0000;
    tick();
    read_status(st);
    checks++;
    if (st !== 8'h02) begin errors++; $display("FAIL post_release_status got=%h exp=%h", st, 8'h02); end
    $display("test_reset done cyc=%0d", cyc);
  endtask

  task automatic test_single();
    logic [7:0] st;
    bus_write(DATA_ADDR, 8'hA5);
    for (int k = 0; k < 46; k++) begin
      read_status(st);
      checks++;
      if (st !== model_status(cyc)) begin errors++; $display("FAIL single_status cyc=%0d got=%h exp=%h", cyc, st, model_status(cyc)); end
      checks++;
      if (tx !== model_tx(cyc)) begin errors++; $display("FAIL single_tx cyc=%0d got=%b exp=%b", cyc, tx, model_tx(cyc)); end
      tick();
    end
    $display("test_single byte=a5 done cyc=%0d", cyc);
  endtask

  task automatic test_back_to_back();
    logic [7:0] st;
    bus_write(DATA_ADDR, 8'h01);
    bus_write(DATA_ADDR, 8'h80);
    for (int k = 0; k < 86; k++) begin
      read_status(st);
      checks++;
      if (st !== model_status(cyc)) begin errors++; $display("FAIL b2b_status cyc=%0d got=%h exp=%h", cyc, st, model_status(cyc)); end
      checks++;
      if (tx !== model_tx(cyc)) begin errors++; $display("FAIL b2b_tx cyc=%0d got=%b exp=%b", cyc, tx, model_tx(cyc)); end
      tick();
    end
    $display("test_back_to_back bytes=01,80 done cyc=%0d", cyc);
  endtask

  task automatic test_overflow();
    logic [7:0] st;
    int e1;
    int frames;
    int busy_until;
    for (int i = 0; i < 6; i++) begin
      bus_write(DATA_ADDR, 8'($urandom));
      if (i == 0) e1 = cyc;
    end
    read_status(st);
    checks++;
    if (st !== 8'h0D || st !== model_status(cyc)) begin
      errors++; $display("FAIL overflow_status got=%h exp=%h", st, model_status(cyc));
    end
    bus_write(STAT_ADDR, 8'h08);
    read_status(st);
    checks++;
    if (st !== model_status(cyc)) begin errors++; $display("FAIL overflow_clear got=%h exp=%h", st, model_status(cyc)); end
    // Frame counter: the first frame started at e1+1, so the line is busy until e1+1+FRAME.
    frames = 1;
    busy_until = e1 + 1 + FRAME;
    for (int k = 0; k < 5 * FRAME + 20; k++) begin
      if (cyc >= busy_until && tx === 1'b0) begin
        frames++;
        busy_until = cyc + FRAME;
      end
      checks++;
      if (tx !== model_tx(cyc)) begin errors++; $display("FAIL overflow_tx cyc=%0d got=%b exp=%b", cyc, tx, model_tx(cyc)); end
      tick();
    end
    checks++;
    if (frames !== 5) begin errors++; $display("FAIL overflow_frames got=%0d exp=5", frames); end
    $display("test_overflow frames=%0d done cyc=%0d", frames, cyc);
  endtask

  task automatic test_interrupt();
    logic [7:0] st;
    bus_write(STAT_ADDR, 8'h80);
    checks++;
    if (irq !== 1'b1 || irq !== model_irq(cyc)) begin errors++; $display("FAIL irq_enable got=%b exp=1", irq); end
    bus_write(DATA_ADDR, 8'h3C);
    checks++;
    if (irq !== 1'b0 || irq !== model_irq(cyc)) begin errors++; $display("FAIL irq_after_write got=%b exp=0", irq); end
    tick();
    checks++;
    if (irq !== 1'b1 || irq !== model_irq(cyc)) begin errors++; $display("FAIL irq_after_pop got=%b exp=1", irq); end
    for (int k = 0; k < 45; k++) begin
      read_status(st);
      checks++;
      if (st !== model_status(cyc) || irq !== model_irq(cyc) || tx !== model_tx(cyc)) begin
        errors++; $display("FAIL irq_frame cyc=%0d st=%h irq=%b tx=%b exp st=%h irq=%b tx=%b",
                           cyc, st, irq, tx, model_status(cyc), model_irq(cyc), model_tx(cyc));
      end
      tick();
    end
    $display("test_interrupt done cyc=%0d", cyc);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] st;
    bus_write(DATA_ADDR, 8'hC3);
    bus_write(DATA_ADDR, 8'h5A);
    bus_write(DATA_ADDR, 8'h0F);
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (tx !== model_tx(cyc)) begin errors++; $display("FAIL mid_pre_tx cyc=%0d got=%b exp=%b", cyc, tx, model_tx(cyc)); end
      tick();
    end
    rst = 1'b0;
    tick();
    model_reset();
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL mid_reset_edge_tx got=%b exp=1", tx); end
    tick();
    rst = 1'b1;
    for (int k = 0; k < 100; k++) begin
      read_status(st);
      checks++;
      if (tx !== 1'b1 || st !== 8'h02 || st !== model_status(cyc)) begin
        errors++; $display("FAIL mid_post_reset cyc=%0d tx=%b st=%h exp tx=1 st=02", cyc, tx, st);
      end
      tick();
    end
    $display("test_reset_mid_frame done cyc=%0d", cyc);
  endtask

  task automatic test_random();
    logic [7:0] st;
    int gap;
    for (int op = 0; op < 40; op++) begin
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 60) : $urandom_range(0, 6);
      for (int k = 0; k < gap; k++) begin
        read_status(st);
        checks++;
        if (st !== model_status(cyc) || irq !== model_irq(cyc) || tx !== model_tx(cyc)) begin
          errors++; $display("FAIL random cyc=%0d st=%h irq=%b tx=%b exp st=%h irq=%b tx=%b",
                             cyc, st, irq, tx, model_status(cyc), model_irq(cyc), model_tx(cyc));
        end
        tick();
      end
      if ($urandom_range(0, 9) == 0) bus_write(STAT_ADDR, 8'($urandom));
      else                           bus_write(DATA_ADDR, 8'($urandom));
    end
    for (int k = 0; k < 6 * FRAME; k++) begin
      read_status(st);
      checks++;
      if (st !== model_status(cyc) || irq !== model_irq(cyc) || tx !== model_tx(cyc)) begin
        errors++; $display("FAIL random_drain cyc=%0d st=%h irq=%b tx=%b exp st=%h irq=%b tx=%b",
                           cyc, st, irq, tx, model_status(cyc), model_irq(cyc), model_tx(cyc));
      end
      tick();
    end
    $display("test_random frames=%0d done cyc=%0d", f_start.size(), cyc);
  endtask

  initial begin
    bus.address    = 16'h0000;
    bus.read_write = 1'b1;
    bus.data_write = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_interrupt();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the CPU's external bus, downstream of the core. It decodes the core's `address`/`read_write`/`data_write` outputs and buffers written bytes in a small FIFO. It serialises the bytes as 8N1 frames on `tx`. It returns status on `data_read`, which the system bus mux selects whenever `select` is high.

## Interface
Parameters:
- `BASE_ADDR`, 16'hD000: base of the two-register window.
  - BASE+0 is DATA.
  - BASE+1 is STATUS/CTRL.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit. Must be ≥2.
- `FIFO_DEPTH`, 4: transmit FIFO entries. Must be a power of two, ≥2.

Ports:
- `clk`  in  1  system clock. All state updates on the rising edge.
- `rst`  in  1  reset. Synchronous and active-low: state resets at a rising edge of `clk` while `rst`=0.
- `address`  in  16  CPU bus address.
- `read_write`  in  1  CPU bus direction: 1 = read, 0 = write.
- `data_write`  in  8  CPU write data.
- `data_read`  out  8  register read data. Combinational from `address` and state. Reads 0x00 when not selected.
- `select`  out  1  high when `address` is BASE+0 or BASE+1. Combinational.
- `tx`  out  1  serial output. Idles high.
- `irq`  out  1  transmit-empty interrupt. Combinational: `irq_en & fifo_empty`.

## Operation
Registers:
- DATA write: pushes `data_write` into the FIFO.
  - If the FIFO is full at that edge, the byte is dropped and `overflow` sets.
  - A full FIFO rejects the push even if a pop occurs on the same edge.
- DATA read: returns 0x00. Has no side effects.
- STATUS read returns these bits:
  - [0] fifo_full
  - [1] fifo_empty
  - [2] tx_active (FSM not IDLE)
  - [3] overflow (sticky)
  - [6:4] 0
  - [7] irq_en
- CTRL write:
  - bit7 loads `irq_en`.
  - bit3 = 1 clears `overflow`.
  - All other bits are ignored.
- Write strobe: `select & ~read_write`. It acts once per clock cycle it is asserted.

FIFO:
- Circular buffer with read and write pointers of log2(FIFO_DEPTH) bits, plus an occupancy count of 0..FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH.
- Pop and a non-full push on the same edge leave the count unchanged.

Transmit FSM:
- IDLE → START when FIFO is non-empty. On that edge, pop the head into the shift register and clear the baud counter.
- START: `tx`=0 for CLKS_PER_BIT cycles → DATA.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit index counts 0..7. After bit 7 → STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. Then:
  - If the FIFO is non-empty, pop and go directly to START (no idle gap).
  - Otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps at bit boundaries.
- `tx` is registered.

Reset values:
- `tx`=1
- FSM=IDLE
- FIFO empty, pointers and count = 0
- `irq_en`=0, `overflow`=0
- Resulting outputs: `irq`=0, STATUS reads 0x02.

Reset mid-frame aborts the frame: `tx` is high from the reset edge and FIFO contents are discarded.

## Timing
- DATA write captured at edge N with the FIFO previously empty and FSM in IDLE:
  - FIFO non-empty after N.
  - Pop at N+1.
  - `tx` falls after N+1 (one-cycle latency).
- Frame length is exactly 10·CLKS_PER_BIT cycles.
- Back-to-back frames are contiguous: the next start bit begins the cycle after the last stop-bit cycle.
- STATUS reflects state as of the last edge, combinationally.
- Writes are visible in STATUS the cycle after the write edge.
- `irq` falls the cycle after a DATA write into an empty FIFO when `irq_en`=1.
- `irq` rises the cycle after the pop that empties the FIFO.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Reset:
  - Stimulus: hold `rst`=0 for 2 edges, then release; read BASE+1 (0xD001).
  - Required: `tx`=1, `irq`=0, `select`=1, STATUS reads 0x02.
- Single byte:
  - Stimulus: write 0xA5 to 0xD000.
  - Required: `tx` low 1 cycle later for 4 cycles, then data bits 1,0,1,0,0,1,0,1 each for 4 cycles, then high for 4 cycles; 40 cycles total.
  - Required: STATUS bit2=1 during the frame and 0 afterwards.
- Back-to-back:
  - Stimulus: write 0x01 and 0x80 on consecutive cycles.
  - Required: two contiguous frames totalling 80 cycles, with no idle cycle between the stop bit and the next start bit.
- Overflow:
  - Stimulus: write 6 bytes on consecutive cycles.
  - Required: the first byte is popped and 4 are buffered; the 6th is dropped.
  - Required: STATUS reads 0x0D (full, active, overflow).
  - Then write 0x08 to 0xD001: overflow clears.
  - Required: exactly 5 frames are transmitted.
- Interrupt:
  - Stimulus: write 0x80 to 0xD001, giving `irq`=1. Then write one byte.
  - Required: `irq`=0 one cycle after the write; `irq`=1 again one cycle after the pop.
- Reset mid-frame:
  - Stimulus: assert `rst`=0 in the data phase with 2 bytes still queued.
  - Required: `tx`=1 from the reset edge, and no frames after release.
